// File: rtl/isqrt_arb_pkg.sv
// Shared constants and round-robin index helpers for the isqrt sharing arbiter.
package isqrt_arb_pkg;

  localparam int ISQRT_X_W     = 32;
  localparam int ISQRT_Y_W     = 16;
  localparam int N_REQ_DEF     = 4;
  localparam int TAG_DEPTH_DEF = 16;

  function automatic int rr_next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  function automatic int rr_wrap_idx(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/flip_flop_fifo_with_counter.sv
// Register-based FIFO with occupancy counter; push when full and pop when empty are ignored.
module flip_flop_fifo_with_counter #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/isqrt_shared_arbiter.sv
// Round-robin front end sharing one pipelined isqrt among N_REQ clients; a tag FIFO routes results back.
// Optional sticky protocol-error output err is enabled with `define ISQRT_ARB_ERR_EN.
module isqrt_shared_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ISQRT_X_W-1:0] req_x,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rsp_vld,
  output logic [ISQRT_Y_W-1:0]       rsp_y,
  output logic                       isqrt_x_vld,
  output logic [ISQRT_X_W-1:0]       isqrt_x,
  input  logic                       isqrt_y_vld,
  input  logic [ISQRT_Y_W-1:0]       isqrt_y,
  output logic                       busy
`ifdef ISQRT_ARB_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  head_id;
  logic             found;
  logic             issue;
  logic             ret;
  logic             fifo_empty, fifo_full;
  int               idx;

  // Priority search starting at the pointer; gated by rst so outputs clear asynchronously.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_wrap_idx(int'(rr_ptr_q), k, N_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  assign issue = found && (cnt_q < CNT_W'(TAG_DEPTH)) && !fifo_full && !rst;
  assign ret   = isqrt_y_vld && !fifo_empty;

  always_comb begin
    gnt         = '0;
    isqrt_x_vld = issue;
    isqrt_x     = '0;
    rsp_vld     = '0;
    rsp_y       = '0;
    if (issue) begin
      gnt     = N_REQ'(1) << gnt_id;
      isqrt_x = req_x[int'(gnt_id)*ISQRT_X_W +: ISQRT_X_W];
    end
    if (ret) begin
      rsp_vld = N_REQ'(1) << head_id;
      rsp_y   = isqrt_y;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (issue) begin
      rr_ptr_d = ID_W'(rr_next_idx(int'(gnt_id), N_REQ));
    end
    if (issue && !ret) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!issue && ret) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

  flip_flop_fifo_with_counter #(
    .WIDTH (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (gnt_id),
    .pop       (ret),
    .pop_data  (head_id),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifdef ISQRT_ARB_ERR_EN
  logic err_q, err_d;

  // A result with no owner, or a push into a full tag FIFO, latches until reset.
  always_comb begin
    err_d = err_q | (isqrt_y_vld & fifo_empty) | (issue & fifo_full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_isqrt_shared_arbiter.sv
// Bench for isqrt_shared_arbiter with a variable-latency isqrt stub and an in-order result scoreboard.
module tb_isqrt_shared_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_x;
  logic [3:0]   gnt;
  logic [3:0]   rsp_vld;
  logic [15:0]  rsp_y;
  logic         isqrt_x_vld;
  logic [31:0]  isqrt_x;
  logic         isqrt_y_vld;
  logic [15:0]  isqrt_y;
  logic         busy;
`ifdef ISQRT_ARB_ERR_EN
  logic         err;
`endif

  int           lat;
  logic         inject;
  logic [7:0]   pipe_v;
  logic [15:0]  pipe_y [8];
  logic [17:0]  exp_q [$];
  int           n_checks;
  int           n_pass;

  isqrt_shared_arbiter #(
    .N_REQ     (4),
    .TAG_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_x       (req_x),
    .gnt         (gnt),
    .rsp_vld     (rsp_vld),
    .rsp_y       (rsp_y),
    .isqrt_x_vld (isqrt_x_vld),
    .isqrt_x     (isqrt_x),
    .isqrt_y_vld (isqrt_y_vld),
    .isqrt_y     (isqrt_y),
    .busy        (busy)
`ifdef ISQRT_ARB_ERR_EN
    ,
    .err         (err)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
    longint r;
    longint t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return r[15:0];
  endfunction

  // ---------------- isqrt stub, latency lat (1..8) ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[6:0], isqrt_x_vld};
      pipe_y[0] <= isqrt_ref(isqrt_x);
      for (int i = 1; i < 8; i++) pipe_y[i] <= pipe_y[i-1];
    end
  end
  assign isqrt_y_vld = pipe_v[lat-1] | inject;
  assign isqrt_y     = pipe_y[lat-1];

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin : mon
      logic [17:0] e;
      int gid;
      if (|(req & gnt)) begin
        gid = 0;
        for (int i = 0; i < 4; i++) if (gnt[i]) gid = i;
        exp_q.push_back({2'(gid), isqrt_ref(req_x[gid*32 +: 32])});
      end
      if (|rsp_vld) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: rsp_vld=%b rsp_y=%0d, none expected", rsp_vld, rsp_y);
        end else begin
          e = exp_q.pop_front();
          if (rsp_vld !== 4'(1 << e[17:16]) || rsp_y !== e[15:0])
            $display("FAIL sb_rsp: got vld=%b y=%0d exp vld=%b y=%0d",
                     rsp_vld, rsp_y, 4'(1 << e[17:16]), e[15:0]);
          else n_pass++;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL %s_drain: pending=%0d busy=%b exp pending=0 busy=0", name, exp_q.size(), busy);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req    = 4'hF;
    req_x  = {32'd9, 32'd16, 32'd25, 32'd36};
    inject = 1'b0;
    lat    = 3;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (gnt !== 4'b0) $display("FAIL rst_gnt: got %b exp 0", gnt); else n_pass++;
    n_checks++; if (rsp_vld !== 4'b0) $display("FAIL rst_rsp_vld: got %b exp 0", rsp_vld); else n_pass++;
    n_checks++; if (rsp_y !== 16'd0) $display("FAIL rst_rsp_y: got %0d exp 0", rsp_y); else n_pass++;
    n_checks++; if (isqrt_x_vld !== 1'b0) $display("FAIL rst_x_vld: got %b exp 0", isqrt_x_vld); else n_pass++;
    n_checks++; if (isqrt_x !== 32'd0) $display("FAIL rst_x: got %0d exp 0", isqrt_x); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
`ifdef ISQRT_ARB_ERR_EN
    n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b exp 0", err); else n_pass++;
`endif
    req = 4'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_rr_all();
    logic [15:0] tbl [4];
    tbl = '{16'd0, 16'd1, 16'd1000, 16'd65535};
    next_cycle();
    req   = 4'hF;
    req_x = {32'hFFFF_FFFF, 32'd1_000_000, 32'd1, 32'd0};
    fork
      begin : drv
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          n_checks++;
          if (gnt !== 4'(1 << (i % 4))) $display("FAIL rr_gnt%0d: got %b exp %b", i, gnt, 4'(1 << (i % 4)));
          else n_pass++;
          next_cycle();
          if (i == 7) req = 4'b0;
        end
      end
      begin : col
        int n;
        n = 0;
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (|rsp_vld) begin
            n_checks++;
            if (n >= 8 || rsp_vld !== 4'(1 << (n % 4)) || rsp_y !== tbl[n % 4] || c != n + lat)
              $display("FAIL rr_rsp%0d: got vld=%b y=%0d cyc=%0d exp vld=%b y=%0d cyc=%0d",
                       n, rsp_vld, rsp_y, c, 4'(1 << (n % 4)), tbl[n % 4], n + lat);
            else n_pass++;
            n++;
          end
        end
        n_checks++; if (n != 8) $display("FAIL rr_rsp_count: got %0d exp 8", n); else n_pass++;
      end
    join
  endtask

  task automatic test_single();
    int k;
    next_cycle();
    req            = 4'b0010;
    req_x[63:32]   = 32'd144;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0010) $display("FAIL single_gnt: got %b exp 0010", gnt); else n_pass++;
    n_checks++;
    if (isqrt_x_vld !== 1'b1 || isqrt_x !== 32'd144)
      $display("FAIL single_issue: got vld=%b x=%0d exp vld=1 x=144", isqrt_x_vld, isqrt_x);
    else n_pass++;
    next_cycle();
    req = 4'b0;
    k   = 1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b exp 1", busy); else n_pass++;
    while (rsp_vld === 4'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (rsp_vld !== 4'b0010 || rsp_y !== 16'd12 || k != lat)
      $display("FAIL single_rsp: got vld=%b y=%0d lat=%0d exp vld=0010 y=12 lat=%0d", rsp_vld, rsp_y, k, lat);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b exp 0", busy); else n_pass++;
  endtask

  // With TAG_DEPTH=4 and latency 3, every cycle after warm-up issues and returns at outstanding = 3.
  task automatic test_back_to_back();
    int exp_ptr;
    int gid;
    exp_ptr = 2;
    next_cycle();
    req = 4'hF;
    for (int i = 0; i < 4; i++) req_x[i*32 +: 32] = $urandom();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      gid = exp_ptr;
      n_checks++;
      if (gnt !== 4'(1 << exp_ptr)) $display("FAIL b2b_gnt%0d: got %b exp %b", i, gnt, 4'(1 << exp_ptr));
      else n_pass++;
      exp_ptr = (exp_ptr + 1) % 4;
      next_cycle();
      req_x[gid*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
    end
    req = 4'b0;
    drain("b2b");
  endtask

  task automatic test_credit();
    int m_cnt;
    int g_early;
    logic exp_g;
    m_cnt   = 0;
    g_early = 0;
    req     = 4'hF;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      exp_g = (m_cnt < 4);
      n_checks++;
      if ((|gnt) !== exp_g || busy !== (m_cnt != 0))
        $display("FAIL credit_c%0d: got gnt=%b busy=%b exp grant=%b busy=%b", c, gnt, busy, exp_g, m_cnt != 0);
      else n_pass++;
      if (c < 8 && |gnt) g_early++;
      m_cnt = m_cnt + int'(exp_g) - int'(isqrt_y_vld);
      next_cycle();
    end
    n_checks++; if (g_early != 4) $display("FAIL credit_first8: got %0d grants exp 4", g_early); else n_pass++;
    req = 4'b0;
    drain("credit");
  endtask

  task automatic test_reset_mid();
    int k;
    logic bad;
    req   = 4'hF;
    req_x = {32'd100, 32'd81, 32'd64, 32'd49};
    repeat (4) next_cycle();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (gnt !== 4'b0 || isqrt_x_vld !== 1'b0 || isqrt_x !== 32'd0)
      $display("FAIL midrst_issue: got gnt=%b vld=%b x=%0d exp all 0", gnt, isqrt_x_vld, isqrt_x);
    else n_pass++;
    n_checks++;
    if (rsp_vld !== 4'b0 || rsp_y !== 16'd0 || busy !== 1'b0)
      $display("FAIL midrst_rsp: got vld=%b y=%0d busy=%b exp all 0", rsp_vld, rsp_y, busy);
    else n_pass++;
    exp_q.delete();
    req = 4'b0;
    next_cycle();
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rsp_vld !== 4'b0) bad = 1'b1;
    end
    n_checks++; if (bad) $display("FAIL midrst_stale: got stale rsp_vld exp none"); else n_pass++;
    next_cycle();
    req = 4'b1000;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b1000) $display("FAIL midrst_gnt: got %b exp 1000", gnt); else n_pass++;
    next_cycle();
    req = 4'b0;
    k   = 1;
    @(negedge clk);
    while (rsp_vld === 4'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (rsp_vld !== 4'b1000 || rsp_y !== 16'd10 || k != lat)
      $display("FAIL midrst_new: got vld=%b y=%0d lat=%0d exp vld=1000 y=10 lat=%0d", rsp_vld, rsp_y, k, lat);
    else n_pass++;
    drain("midrst");
  endtask

  task automatic test_err();
    next_cycle();
    inject = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rsp_vld !== 4'b0 || rsp_y !== 16'd0)
      $display("FAIL err_rsp: got vld=%b y=%0d exp vld=0 y=0", rsp_vld, rsp_y);
    else n_pass++;
    next_cycle();
    inject = 1'b0;
`ifdef ISQRT_ARB_ERR_EN
    n_checks++; if (err !== 1'b1) $display("FAIL err_rise: got %b exp 1", err); else n_pass++;
`endif
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL err_busy: got %b exp 0", busy); else n_pass++;
`ifdef ISQRT_ARB_ERR_EN
    n_checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", err); else n_pass++;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    inject   = 1'b0;
    lat      = 3;
    req      = 4'b0;
    req_x    = '0;
    test_reset();
    test_rr_all();
    test_single();
    test_back_to_back();
    repeat (10) next_cycle();
    lat = 8;
    test_credit();
    test_reset_mid();
    repeat (10) next_cycle();
    lat = 3;
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
